bpm_beat_tracker: RTL

Downstream consumer of the BPM estimator's `final_BPM_estimate`. Smooths the raw BPM stream, converts it to a beat period in clock cycles using an iterative divider, and runs a free-running beat counter that emits a single-cycle `beat_pulse` at the tracked tempo. It also outputs a confidence level that drives the `beat_strength` indicator.

---
 rtl/bpm_beat_tracker_if.sv | 21 ++
 rtl/bpm_beat_tracker.sv | 193 +++++++++++++++++++
 2 files changed

// File: rtl/bpm_beat_tracker_if.sv
// Sample/status bus between the BPM estimator (master) and the beat tracker (slave).
interface bpm_beat_tracker_if;
  logic [15:0] bpm_in;
  logic        bpm_in_valid;
  logic [15:0] bpm_smoothed;
  logic [31:0] period_cycles;
  logic        beat_pulse;
  logic [3:0]  beat_strength;
  logic        locked;
  logic        busy;

  modport master (
    output bpm_in, bpm_in_valid,
    input  bpm_smoothed, period_cycles, beat_pulse, beat_strength, locked, busy
  );

  modport slave (
    input  bpm_in, bpm_in_valid,
    output bpm_smoothed, period_cycles, beat_pulse, beat_strength, locked, busy
  );
endinterface

// File: rtl/bpm_beat_tracker.sv
// Beat tracker: EMA-smooths the raw BPM stream, divides (CLK_HZ*60) by the
// smoothed BPM with a 32-step restoring divider, and runs a free-running
// beat counter whose period changes only at beat boundaries.
// Optional build macro BPM_TRACKER_LOCK_GATE_EN: when defined, beat_pulse is
// suppressed while the tracker is not locked (the counter keeps running).
module bpm_beat_tracker #(
  parameter int unsigned CLK_HZ    = 50_000_000,
  parameter int unsigned BPM_MIN   = 60,
  parameter int unsigned BPM_MAX   = 200,
  parameter int unsigned AVG_SHIFT = 2,
  parameter int unsigned BPM_TOL   = 4
) (
  input logic               clk,
  input logic               reset,
  bpm_beat_tracker_if.slave bus
);

  localparam logic [31:0] DIVIDEND  = 32'(CLK_HZ * 60);
  localparam logic [15:0] BPM_MIN_W = 16'(BPM_MIN);
  localparam logic [15:0] BPM_MAX_W = 16'(BPM_MAX);
  localparam logic [15:0] BPM_TOL_W = 16'(BPM_TOL);

  typedef enum logic [1:0] {ST_IDLE, ST_DIV, ST_RUN} state_e;

  state_e      state_q, state_d;
  logic [17:0] ema_q, ema_d;         // smoothed BPM, 2 fractional bits
  logic        seen_q, seen_d;       // at least one sample accepted
  logic [3:0]  conf_q, conf_d;
  logic        redo_q, redo_d;       // one queued divide request
  logic [15:0] divisor_q, divisor_d;
  logic [31:0] quot_q, quot_d;       // dividend shifts out, quotient shifts in
  logic [15:0] rem_q, rem_d;
  logic [4:0]  iter_q, iter_d;
  logic [31:0] pending_q, pending_d;
  logic [31:0] period_q, period_d;
  logic [31:0] beat_cnt_q, beat_cnt_d;
  logic        active_q, active_d;   // a beat period is loaded

  logic               accept;
  logic signed [18:0] ema_diff, ema_step, ema_sum;
  logic [15:0]        abs_err;
  logic [16:0]        rem_shift, rem_next;
  logic               q_bit;
  logic [31:0]        quot_next;
  logic               start_div, load_first, wrap;
  logic               unused_bits;

  assign accept = bus.bpm_in_valid && (bus.bpm_in >= BPM_MIN_W) && (bus.bpm_in <= BPM_MAX_W);

  // EMA update and confidence tracking against the pre-update smoothed value.
  always_comb begin
    // NOTE: every signal gets a default first so no path infers a latch.
    ema_d    = ema_q;
    seen_d   = seen_q;
    conf_d   = conf_q;
    ema_diff = $signed({1'b0, bus.bpm_in, 2'b00}) - $signed({1'b0, ema_q});
    ema_step = ema_diff >>> AVG_SHIFT;
    ema_sum  = $signed({1'b0, ema_q}) + ema_step;
    abs_err  = (bus.bpm_in >= ema_q[17:2]) ? (bus.bpm_in - ema_q[17:2])
                                           : (ema_q[17:2] - bus.bpm_in);
    if (accept) begin
      seen_d = 1'b1;
      if (!seen_q) begin
        ema_d = {bus.bpm_in, 2'b00};
      end else begin
        ema_d = ema_sum[17:0];
        if (abs_err <= BPM_TOL_W) begin
          if (conf_q != 4'hF) conf_d = conf_q + 4'd1;
        end else if (conf_q != 4'h0) begin
          conf_d = conf_q - 4'd1;
        end
      end
    end
  end

  // One restoring-divide step per DIV cycle.
  always_comb begin
    rem_shift = {rem_q, quot_q[31]};
    q_bit     = (rem_shift >= {1'b0, divisor_q});
    rem_next  = q_bit ? (rem_shift - {1'b0, divisor_q}) : rem_shift;
    quot_next = {quot_q[30:0], q_bit};
  end

  // FSM next state, divide sequencing and request queueing.
  always_comb begin
    state_d    = state_q;
    redo_d     = redo_q;
    divisor_d  = divisor_q;
    quot_d     = quot_q;
    rem_d      = rem_q;
    iter_d     = iter_q;
    pending_d  = pending_q;
    start_div  = 1'b0;
    load_first = 1'b0;
    case (state_q)
      ST_IDLE, ST_RUN: begin
        if (accept) start_div = 1'b1;
      end
      ST_DIV: begin
        quot_d = quot_next;
        rem_d  = rem_next[15:0];
        iter_d = iter_q + 5'd1;
        if (accept) redo_d = 1'b1;
        if (iter_q == 5'd31) begin
          pending_d  = quot_next;
          load_first = !active_q;
          redo_d     = 1'b0;
          // A request queued earlier, or one arriving right now, gets one more pass.
          if (redo_q || accept) start_div = 1'b1;
          else                  state_d   = ST_RUN;
        end
      end
      default: state_d = ST_IDLE;
    endcase
    // The divisor is taken from the EMA value being written this cycle.
    if (start_div) begin
      state_d   = ST_DIV;
      divisor_d = ema_d[17:2];
      quot_d    = DIVIDEND;
      rem_d     = '0;
      iter_d    = '0;
    end
  end

  // Beat counter: counts period-1 down to 0, wrapping onto the pending period.
  always_comb begin
    beat_cnt_d = beat_cnt_q;
    period_d   = period_q;
    active_d   = active_q;
    wrap       = active_q && (beat_cnt_q == 32'd0);
    if (wrap) begin
      beat_cnt_d = pending_q - 32'd1;
      period_d   = pending_q;
    end else if (active_q) begin
      beat_cnt_d = beat_cnt_q - 32'd1;
    end
    // First result ever loads straight into the counter (never coincides with a wrap).
    if (load_first) begin
      active_d   = 1'b1;
      period_d   = quot_next;
      beat_cnt_d = quot_next - 32'd1;
    end
  end

  // State registers, all cleared asynchronously.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q    <= ST_IDLE;
      ema_q      <= '0;
      seen_q     <= 1'b0;
      conf_q     <= '0;
      redo_q     <= 1'b0;
      divisor_q  <= '0;
      quot_q     <= '0;
      rem_q      <= '0;
      iter_q     <= '0;
      pending_q  <= '0;
      period_q   <= '0;
      beat_cnt_q <= '0;
      active_q   <= 1'b0;
    end else begin
      // NOTE: non-blocking so every flop samples the values from before the edge.
      state_q    <= state_d;
      ema_q      <= ema_d;
      seen_q     <= seen_d;
      conf_q     <= conf_d;
      redo_q     <= redo_d;
      divisor_q  <= divisor_d;
      quot_q     <= quot_d;
      rem_q      <= rem_d;
      iter_q     <= iter_d;
      pending_q  <= pending_d;
      period_q   <= period_d;
      beat_cnt_q <= beat_cnt_d;
      active_q   <= active_d;
    end
  end

  assign bus.bpm_smoothed  = ema_q[17:2];
  assign bus.period_cycles = period_q;
  assign bus.beat_strength = conf_q;
  assign bus.locked        = conf_q[3];
  assign bus.busy          = (state_q == ST_DIV);
`ifdef BPM_TRACKER_LOCK_GATE_EN
  assign bus.beat_pulse    = wrap && conf_q[3];
`else
  assign bus.beat_pulse    = wrap;
`endif

  // Top bits that are provably zero for in-range operands.
  assign unused_bits = ema_sum[18] ^ rem_next[16];

endmodule
